flash_program_controller: RTL and testbench

- Write-side companion to the paged-read flash controller; drives Intel StrataFlash program and block-erase command sequences on the shared SF_* pins.
- Polls the status register until the device is ready, clears any error bits, then returns the device to read-array mode so paged reads can resume.
- Sits between the bootloader/host datapath and the flash pins; it owns the pins only while busy=1, and pin muxing sits outside this block.

---
 rtl/flash_pkg.sv | 41 ++++
 rtl/flash_bus_cycle.sv | 108 ++++++++++
 rtl/flash_program_controller.sv | 192 +++++++++++++++++++
 tb/tb_flash_program_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_pkg : StrataFlash command codes, status bits, FSM state types   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package flash_pkg;

  localparam logic [7:0] CMD_PROGRAM      = 8'h40;
  localparam logic [7:0] CMD_ERASE        = 8'h20;
  localparam logic [7:0] CMD_CONFIRM      = 8'hD0;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
  localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
  localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK      = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD1,
    ST_CMD2,
    ST_STAT_CMD,
    ST_POLL,
    ST_CHECK,
    ST_CLR,
    ST_RDARRAY,
    ST_FIN
  } fpc_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_WR,
    PH_RD,
    PH_REC
  } bus_phase_e;

endpackage
`default_nettype wire

// File: rtl/flash_bus_cycle.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_bus_cycle : one timed flash write (WR) or status read (RD)      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ROM_ADDR = 24,
  parameter int T_WE     = 2,
  parameter int T_WH     = 2,
  parameter int T_RD     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_read,
  input  logic [WIDTH-1:0]    i_cmd,
  input  logic [ROM_ADDR-1:0] i_addr,
  output logic                o_idle,
  output logic                o_cycle_done,
  output logic                o_sample,
  output logic [WIDTH-1:0]    o_sf_d_out,
  output logic                o_sf_d_oe,
  output logic [ROM_ADDR-1:0] o_sf_a,
  output logic                o_sf_ce_n,
  output logic                o_sf_oe_n,
  output logic                o_sf_we_n
);

  localparam int CW = $clog2(T_WE + T_WH + T_RD + 1) + 1;
  localparam logic [CW-1:0] c_wr_last = CW'(T_WE + T_WH);
  localparam logic [CW-1:0] c_we_last = CW'(T_WE);
  localparam logic [CW-1:0] c_rd_last = CW'(T_RD - 1);

  bus_phase_e          r_phase;
  bus_phase_e          w_phase_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic [WIDTH-1:0]    r_cmd;
  logic [ROM_ADDR-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
      if (i_start && r_phase == PH_IDLE) begin
        r_addr <= i_addr;
        if (!i_read) r_cmd <= i_cmd;
      end
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt;
    o_cycle_done = 1'b0;
    o_sample     = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        if (i_start) begin
          w_phase_next = i_read ? PH_RD : PH_WR;
          w_cnt_next   = '0;
        end
      end
      PH_WR: begin
        if (r_cnt == c_wr_last) begin
          o_cycle_done = 1'b1;
          w_phase_next = PH_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      PH_RD: begin
        if (r_cnt == c_rd_last) begin
          o_sample     = 1'b1;
          w_phase_next = PH_REC;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      PH_REC: begin
        o_cycle_done = 1'b1;
        w_phase_next = PH_IDLE;
      end
      default: w_phase_next = PH_IDLE;
    endcase
  end

  // WE is low only in clocks 1..T_WE of a write; clock 0 is address/data setup.
  assign o_idle     = (r_phase == PH_IDLE);
  assign o_sf_d_out = r_cmd;
  assign o_sf_d_oe  = (r_phase == PH_WR);
  assign o_sf_a     = r_addr;
  assign o_sf_ce_n  = !((r_phase == PH_WR) || (r_phase == PH_RD));
  assign o_sf_oe_n  = !(r_phase == PH_RD);
  assign o_sf_we_n  = !((r_phase == PH_WR) && (r_cnt != '0) && (r_cnt <= c_we_last));

endmodule
`default_nettype wire

// File: rtl/flash_program_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_program_controller : StrataFlash program / block-erase sequencer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module flash_program_controller
  import flash_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ROM_ADDR   = 24,
  parameter int T_WE       = 2,
  parameter int T_WH       = 2,
  parameter int T_RD       = 4,
  parameter int POLL_LIMIT = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ROM_ADDR-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                start_prog,
  input  logic                start_erase,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WIDTH-1:0]    status,
  output logic                timeout,
  input  logic [WIDTH-1:0]    SF_D_in,
  output logic [WIDTH-1:0]    SF_D_out,
  output logic                SF_D_oe,
  output logic [ROM_ADDR-1:0] SF_A,
  output logic                SF_CE0,
  output logic                SF_OE,
  output logic                SF_WE,
  output logic                SF_BYTE
);

  localparam int PW = $clog2(POLL_LIMIT) + 1;
  localparam logic [PW-1:0] c_poll_limit = PW'(POLL_LIMIT);

  fpc_state_e          r_state;
  fpc_state_e          w_state_next;
  logic [ROM_ADDR-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic                r_erase;
  logic                r_issued;
  logic [PW-1:0]       r_poll_cnt;
  logic [PW-1:0]       w_poll_next;
  logic [WIDTH-1:0]    r_status;
  logic                r_error;
  logic                r_timeout;

  logic                w_accept;
  logic                w_cmd_state;
  logic                w_bus_read;
  logic [WIDTH-1:0]    w_bus_cmd;
  logic                w_bus_start;
  logic                w_bus_idle;
  logic                w_bus_done;
  logic                w_bus_sample;
  logic                w_sr_err;
  logic                w_poll_expired;

  assign w_accept       = (r_state == ST_IDLE) && (start_prog || start_erase);
  assign w_poll_next    = (r_poll_cnt == '1) ? r_poll_cnt : r_poll_cnt + PW'(1);
  assign w_poll_expired = (w_poll_next >= c_poll_limit);
  assign w_sr_err       = r_status[SR_ERASE_ERR] | r_status[SR_PROG_ERR] |
                          r_status[SR_VPP_ERR]   | r_status[SR_LOCK];
  // Each command state launches exactly one bus cycle, then waits for it.
  assign w_bus_start    = w_cmd_state && w_bus_idle && !r_issued;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_erase    <= 1'b0;
      r_issued   <= 1'b0;
      r_poll_cnt <= '0;
      r_status   <= '0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_bus_start)     r_issued <= 1'b1;
      else if (w_bus_done) r_issued <= 1'b0;
      if (w_accept) begin
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_erase    <= !start_prog;
        r_poll_cnt <= '0;
        r_status   <= '0;
        r_error    <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_bus_sample) r_status <= SF_D_in;
      if (r_state == ST_POLL && w_bus_done && !r_status[SR_READY]) begin
        r_poll_cnt <= w_poll_next;
        if (w_poll_expired) begin
          r_timeout <= 1'b1;
          r_error   <= 1'b1;
        end
      end
      if (r_state == ST_CHECK) r_error <= w_sr_err;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_state  = 1'b1;
    w_bus_read   = 1'b0;
    w_bus_cmd    = WIDTH'(CMD_READ_ARRAY);
    case (r_state)
      ST_IDLE: begin
        w_cmd_state = 1'b0;
        if (w_accept) w_state_next = ST_CMD1;
      end
      ST_CMD1: begin
        w_bus_cmd = r_erase ? WIDTH'(CMD_ERASE) : WIDTH'(CMD_PROGRAM);
        if (w_bus_done) w_state_next = ST_CMD2;
      end
      ST_CMD2: begin
        w_bus_cmd = r_erase ? WIDTH'(CMD_CONFIRM) : r_wdata;
        if (w_bus_done) w_state_next = ST_STAT_CMD;
      end
      ST_STAT_CMD: begin
        w_bus_cmd = WIDTH'(CMD_READ_STATUS);
        if (w_bus_done) w_state_next = ST_POLL;
      end
      ST_POLL: begin
        w_bus_read = 1'b1;
        if (w_bus_done) begin
          if (r_status[SR_READY]) w_state_next = ST_CHECK;
          else if (w_poll_expired) w_state_next = ST_RDARRAY;
          else w_state_next = ST_POLL;
        end
      end
      ST_CHECK: begin
        w_cmd_state  = 1'b0;
        w_state_next = w_sr_err ? ST_CLR : ST_RDARRAY;
      end
      ST_CLR: begin
        w_bus_cmd = WIDTH'(CMD_CLEAR_STATUS);
        if (w_bus_done) w_state_next = ST_RDARRAY;
      end
      ST_RDARRAY: begin
        w_bus_cmd = WIDTH'(CMD_READ_ARRAY);
        if (w_bus_done) w_state_next = ST_FIN;
      end
      ST_FIN: begin
        w_cmd_state  = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cmd_state  = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  flash_bus_cycle #(
    .WIDTH    (WIDTH),
    .ROM_ADDR (ROM_ADDR),
    .T_WE     (T_WE),
    .T_WH     (T_WH),
    .T_RD     (T_RD)
  ) u_bus (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_bus_start),
    .i_read       (w_bus_read),
    .i_cmd        (w_bus_cmd),
    .i_addr       (r_addr),
    .o_idle       (w_bus_idle),
    .o_cycle_done (w_bus_done),
    .o_sample     (w_bus_sample),
    .o_sf_d_out   (SF_D_out),
    .o_sf_d_oe    (SF_D_oe),
    .o_sf_a       (SF_A),
    .o_sf_ce_n    (SF_CE0),
    .o_sf_oe_n    (SF_OE),
    .o_sf_we_n    (SF_WE)
  );

  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done    = (r_state == ST_FIN);
  assign error   = r_error;
  assign status  = r_status;
  assign timeout = r_timeout;
  assign SF_BYTE = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_flash_program_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_flash_program_controller : bench with behavioural StrataFlash model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_flash_program_controller;

  localparam int T_WE  = 2;
  localparam int T_WH  = 2;
  localparam int T_RD  = 4;
  localparam int LIMIT = 4;
  localparam int NEVER = 255;

  typedef struct {
    bit          erase;
    bit          both;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          ready;
    logic [7:0]  fin;
    bit          exp_err;
    bit          exp_to;
    logic [7:0]  exp_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        start_prog = 1'b0;
  logic        start_erase = 1'b0;
  logic        busy, done, error, timeout, SF_D_oe, SF_CE0, SF_OE, SF_WE, SF_BYTE;
  logic [7:0]  status, SF_D_in, SF_D_out;
  logic [23:0] SF_A;

  int vectors = 0;
  int miscompares = 0;

  // flash model configuration (written by the stimulus process)
  int         ready_after = NEVER;
  logic [7:0] fin_st = 8'h80;
  int         rd_base = 0;

  // bus monitor logs (written only by the monitor)
  logic [8:0]  ops[$];
  int          we_q[$];
  int          wr_q[$];
  int          rd_q[$];
  logic [23:0] a_q[$];
  int          rd_count = 0;
  int          done_count = 0;

  logic [8:0]  exp_q[$];
  bit          m_err, m_to;
  logic [7:0]  m_st;

  always #5 clk = ~clk;

  flash_program_controller #(
    .WIDTH(8), .ROM_ADDR(24), .T_WE(T_WE), .T_WH(T_WH), .T_RD(T_RD), .POLL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .start_prog(start_prog), .start_erase(start_erase),
    .busy(busy), .done(done), .error(error), .status(status), .timeout(timeout),
    .SF_D_in(SF_D_in), .SF_D_out(SF_D_out), .SF_D_oe(SF_D_oe), .SF_A(SF_A),
    .SF_CE0(SF_CE0), .SF_OE(SF_OE), .SF_WE(SF_WE), .SF_BYTE(SF_BYTE)
  );

  // Status returned by the n-th read of the operation: ready from read number ready_after on.
  assign SF_D_in = (!SF_OE && (rd_count - rd_base + 1 >= ready_after)) ? fin_st : 8'h00;

  int we_low = 0, ce_low = 0, oe_low = 0;
  bit prev_we = 1, prev_ce = 1, prev_oe = 1, wr_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      we_low = 0; ce_low = 0; oe_low = 0;
      prev_we = 1; prev_ce = 1; prev_oe = 1; wr_run = 0;
    end else begin
      if (!SF_WE) we_low++;
      if (SF_WE && !prev_we) begin
        ops.push_back({1'b0, SF_D_out});
        we_q.push_back(we_low);
        a_q.push_back(SF_A);
        we_low = 0;
      end
      if (!SF_CE0) ce_low++;
      if (!SF_CE0 && SF_D_oe) wr_run = 1;
      if (SF_CE0 && !prev_ce) begin
        if (wr_run) wr_q.push_back(ce_low);
        ce_low = 0; wr_run = 0;
      end
      if (!SF_OE) oe_low++;
      if (SF_OE && !prev_oe) begin
        ops.push_back(9'h100);
        rd_q.push_back(oe_low);
        rd_count++;
        oe_low = 0;
      end
      if (done) done_count++;
      prev_we = SF_WE; prev_ce = SF_CE0; prev_oe = SF_OE;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: command list of a program/erase from the device's rules.
  task automatic build_model(input vec_t v);
    int nreads;
    exp_q.delete();
    exp_q.push_back(v.erase ? 9'h020 : 9'h040);
    exp_q.push_back(v.erase ? 9'h0D0 : {1'b0, v.wdata});
    exp_q.push_back(9'h070);
    nreads = (v.ready <= LIMIT) ? v.ready : LIMIT;
    for (int i = 0; i < nreads; i++) exp_q.push_back(9'h100);
    m_to  = (v.ready > LIMIT);
    m_st  = m_to ? 8'h00 : v.fin;
    m_err = m_to || ((v.fin & 8'h3A) != 8'h00);
    if (!m_to && m_err) exp_q.push_back(9'h050);
    exp_q.push_back(9'h0FF);
  endtask

  task automatic run_op(input vec_t v);
    int ob, wb, ab, rb, wrb, db, n, nbad, bad_idx;
    logic [8:0] bad_val;
    build_model(v);
    @(negedge clk);
    ob = ops.size(); wb = we_q.size(); ab = a_q.size(); rb = rd_q.size();
    wrb = wr_q.size(); db = done_count;
    ready_after = v.ready; fin_st = v.fin; rd_base = rd_count;
    addr = v.addr; wdata = v.wdata;
    start_prog  = !v.erase || v.both;
    start_erase = v.erase || v.both;
    @(negedge clk);
    start_prog = 0; start_erase = 0;
    chk("busy_after_start", busy, 1);
    if (v.both) begin
      repeat (5) @(negedge clk);
      start_erase = 1; addr = 24'hFFFFFF;
      @(negedge clk);
      start_erase = 0;
    end
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("error_at_done", error, v.exp_err);
    chk("timeout_at_done", timeout, v.exp_to);
    chk("status_at_done", status, v.exp_st);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("error_held", error, v.exp_err);
    repeat (30) @(negedge clk);
    chk("done_pulse_count", done_count - db, 1);
    bad_idx = -1; bad_val = '0;
    for (int i = 0; i < exp_q.size() && i < ops.size() - ob; i++)
      if (bad_idx < 0 && ops[ob + i] !== exp_q[i]) begin
        bad_idx = i; bad_val = ops[ob + i];
      end
    vectors++;
    if (bad_idx >= 0 || ops.size() - ob != exp_q.size()) begin
      miscompares++;
      $display("FAIL op_sequence: got %0d bus ops (first bad idx %0d = %03h), expected %0d ops",
               ops.size() - ob, bad_idx, bad_val, exp_q.size());
    end
    nbad = 0;
    for (int i = wb; i < we_q.size(); i++) if (we_q[i] != T_WE) nbad++;
    for (int i = wrb; i < wr_q.size(); i++) if (wr_q[i] != 1 + T_WE + T_WH) nbad++;
    for (int i = rb; i < rd_q.size(); i++) if (rd_q[i] != T_RD) nbad++;
    chk("strobe_timing_bad", nbad, 0);
    nbad = 0;
    for (int i = ab; i < a_q.size(); i++) if (a_q[i] !== v.addr) nbad++;
    chk("write_addr_bad", nbad, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   n;

  initial begin
    //          erase both addr        wdata  ready  fin    err to st
    tbl[0] = '{1'b0, 1'b0, 24'h000123, 8'hA5, 3,     8'h80, 0, 0, 8'h80};
    tbl[1] = '{1'b1, 1'b0, 24'h020000, 8'h00, 1,     8'h80, 0, 0, 8'h80};
    tbl[2] = '{1'b0, 1'b0, 24'h000456, 8'h5A, 1,     8'h90, 1, 0, 8'h90};
    tbl[3] = '{1'b0, 1'b0, 24'h00BEEF, 8'h77, NEVER, 8'h80, 1, 1, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 24'h00ABCD, 8'h11, 2,     8'h80, 0, 0, 8'h80};
    tbl[5] = '{1'b1, 1'b0, 24'h040000, 8'h00, 4,     8'hA0, 1, 0, 8'hA0};
    tbl[6] = '{1'b0, 1'b0, 24'h7FFFFF, 8'h00, 2,     8'h82, 1, 0, 8'h82};
    tbl[7] = '{1'b0, 1'b0, 24'h000001, 8'hFF, 1,     8'hC5, 0, 0, 8'hC5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {busy, done, error, timeout, status}, 12'h000);
    chk("reset_strobes", {SF_CE0, SF_OE, SF_WE, SF_D_oe, SF_BYTE}, 5'b11100);
    chk("reset_bus", {SF_A, SF_D_out}, 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      rv.both  = ($urandom_range(0, 3) == 0);
      rv.erase = rv.both ? 1'b0 : 1'($urandom_range(0, 1));
      rv.addr  = 24'($urandom);
      rv.wdata = 8'($urandom);
      rv.ready = $urandom_range(1, LIMIT + 2);
      rv.fin   = {1'b1, 7'($urandom)};
      build_model(rv);
      rv.exp_err = m_err; rv.exp_to = m_to; rv.exp_st = m_st;
      run_op(rv);
    end

    // Reset while CMD2 has WE low: everything must drop at the next edge.
    @(negedge clk);
    ready_after = 1; fin_st = 8'h80; rd_base = rd_count;
    addr = 24'h001234; wdata = 8'h3C; start_prog = 1;
    @(negedge clk);
    start_prog = 0;
    n = 0;
    while (!(SF_D_out == 8'h3C && !SF_WE && !SF_CE0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd2_we_low_reached", (n < 300), 1);
    rst = 1;
    @(negedge clk);
    chk("midop_reset_strobes", {busy, done, SF_WE, SF_CE0, SF_D_oe, SF_OE}, 6'b001101);
    chk("midop_reset_bus", {SF_A, SF_D_out}, 32'h0);
    chk("midop_reset_flags", {error, timeout, status}, 10'h000);
    rst = 0;
    n = done_count;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", done_count - n, 0);
    chk("idle_after_reset", {busy, SF_CE0, SF_WE}, 3'b011);

    run_op(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
